sd_sector_streamer: RTL and testbench

Sits directly downstream of the SD SPI controller and sequences multi-block reads from it. On a start request it fetches a run of consecutive 512-byte blocks. It issues one read per block using SDHC block addressing and counts the controller's byte strobes. Each byte is written into the frame/GIF byte buffer as a byte-addressed write port with an auto-incrementing address. It reports completion, progress and timeout errors to the GIF decoder/display control FSM.

---
 rtl/sd_sector_streamer.sv | 223 ++++++++++++++++++++++
 tb/tb_sd_sector_streamer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sd_sector_streamer                                           |
// | Description : Sequences multi-block reads from the SD SPI controller and   |
// |               streams every received byte into a byte-addressed buffer    |
// |               write port with an auto-incrementing, wrapping address.     |
// | Ports       : clk/reset (async, active-low), start + run parameters        |
// |               (start_block, num_blocks, buf_base), controller handshake   |
// |               (sd_ready, sd_byte_available, sd_dout, sd_rd, sd_address),  |
// |               buffer write port (buf_we, buf_addr, buf_data) and status   |
// |               (busy, done, error, blocks_done). All outputs registered.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sd_sector_streamer #(
   parameter int BYTES_PER_BLOCK = 512,
   parameter int BUF_ADDR_WIDTH  = 17,
   parameter int CNT_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES  = 2_500_000
) (
   input  logic                      clk,
   input  logic                      reset,             // active-low, asynchronous
   input  logic                      start,
   input  logic [31:0]               start_block,
   input  logic [CNT_WIDTH-1:0]      num_blocks,
   input  logic [BUF_ADDR_WIDTH-1:0] buf_base,
   input  logic                      sd_ready,
   input  logic                      sd_byte_available,
   input  logic [7:0]                sd_dout,
   output logic                      sd_rd,
   output logic [31:0]               sd_address,
   output logic                      buf_we,
   output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
   output logic [7:0]                buf_data,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [CNT_WIDTH-1:0]      blocks_done
);

   localparam int BC_W = $clog2(BYTES_PER_BLOCK + 1);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BC_W-1:0]           BC_ONE   = BC_W'(1);
   localparam logic [BC_W-1:0]           BC_LAST  = BC_W'(BYTES_PER_BLOCK - 1);
   localparam logic [WD_W-1:0]           WD_ONE   = WD_W'(1);
   localparam logic [WD_W-1:0]           WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [BUF_ADDR_WIDTH-1:0] ADDR_ONE = BUF_ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_READY = 3'd1,
      S_ISSUE      = 3'd2,
      S_RECEIVE    = 3'd3,
      S_BLOCK_END  = 3'd4,
      S_DONE       = 3'd5,
      S_ERROR      = 3'd6
   } state_t;

   state_t                    state_q, state_d;
   logic                      sd_rd_q, sd_rd_d;
   logic [31:0]               sd_address_q, sd_address_d;
   logic                      buf_we_q, buf_we_d;
   logic [BUF_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]                buf_data_q, buf_data_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;
   logic [CNT_WIDTH-1:0]      blocks_done_q, blocks_done_d;
   logic [CNT_WIDTH-1:0]      remaining_q, remaining_d;
   logic [BC_W-1:0]           byte_cnt_q, byte_cnt_d;
   // buf_addr must show the address of the write in progress, so the
   // post-incremented pointer lives in a separate register.
   logic [BUF_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [WD_W-1:0]           wd_q, wd_d;
   logic                      waiting;

   always_comb begin
      state_d       = state_q;
      sd_rd_d       = sd_rd_q;
      sd_address_d  = sd_address_q;
      buf_we_d      = 1'b0;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      error_d       = error_q;
      blocks_done_d = blocks_done_q;
      remaining_d   = remaining_q;
      byte_cnt_d    = byte_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      wd_d          = wd_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sd_address_d  = start_block;
               remaining_d   = num_blocks;
               buf_addr_d    = buf_base;
               wr_ptr_d      = buf_base;
               error_d       = 1'b0;
               blocks_done_d = '0;
               busy_d        = 1'b1;
               state_d       = (num_blocks == '0) ? S_DONE : S_WAIT_READY;
            end
         end
         S_WAIT_READY: begin
            if (sd_ready) begin
               sd_rd_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Keep sd_rd up until the controller drops ready, so it cannot
            // miss the request nor start a second read for the same block.
            if (!sd_ready) begin
               sd_rd_d    = 1'b0;
               byte_cnt_d = '0;
               state_d    = S_RECEIVE;
            end
         end
         S_RECEIVE: begin
            if (sd_byte_available) begin
               buf_we_d   = 1'b1;
               buf_data_d = sd_dout;
               buf_addr_d = wr_ptr_q;
               wr_ptr_d   = wr_ptr_q + ADDR_ONE;
               byte_cnt_d = byte_cnt_q + BC_ONE;
            end
            if (sd_byte_available && byte_cnt_q == BC_LAST) begin
               state_d = S_BLOCK_END;
            end else if (sd_ready) begin
               // Controller went idle before delivering a full block.
               error_d = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_BLOCK_END: begin
            // Ready returns only after the controller has consumed the CRC.
            if (sd_ready) begin
               blocks_done_d = blocks_done_q + CNT_ONE;
               remaining_d   = remaining_q - CNT_ONE;
               sd_address_d  = sd_address_q + 32'd1;
               state_d       = (remaining_q == CNT_ONE) ? S_DONE : S_WAIT_READY;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ERROR: begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            sd_rd_d = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Watchdog: any forward progress (state change or byte) restarts it.
      waiting = (state_q == S_WAIT_READY) || (state_q == S_ISSUE) ||
                (state_q == S_RECEIVE)    || (state_q == S_BLOCK_END);
      if (waiting && state_d == state_q && !sd_byte_available && wd_q == WD_LAST) begin
         state_d = S_ERROR;
         error_d = 1'b1;
         sd_rd_d = 1'b0;   // a timeout in S_ISSUE leaves the request raised
      end
      if (state_d != state_q || sd_byte_available || !waiting) begin
         wd_d = '0;
      end else begin
         wd_d = wd_q + WD_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         sd_rd_q       <= 1'b0;
         sd_address_q  <= '0;
         buf_we_q      <= 1'b0;
         buf_addr_q    <= '0;
         buf_data_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         blocks_done_q <= '0;
         remaining_q   <= '0;
         byte_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         sd_rd_q       <= sd_rd_d;
         sd_address_q  <= sd_address_d;
         buf_we_q      <= buf_we_d;
         buf_addr_q    <= buf_addr_d;
         buf_data_q    <= buf_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         blocks_done_q <= blocks_done_d;
         remaining_q   <= remaining_d;
         byte_cnt_q    <= byte_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         wd_q          <= wd_d;
      end
   end

   assign sd_rd       = sd_rd_q;
   assign sd_address  = sd_address_q;
   assign buf_we      = buf_we_q;
   assign buf_addr    = buf_addr_q;
   assign buf_data    = buf_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign blocks_done = blocks_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sd_sector_streamer                                        |
// | Description : Directed bench for sd_sector_streamer with an SD controller |
// |               model and a write scoreboard (address + data per byte).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sd_sector_streamer;

   localparam int AW = 17;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   start_block;
   logic [CW-1:0] num_blocks;
   logic [AW-1:0] buf_base;
   logic          sd_ready;
   logic          sd_byte_available;
   logic [7:0]    sd_dout;
   logic          sd_rd;
   logic [31:0]   sd_address;
   logic          buf_we;
   logic [AW-1:0] buf_addr;
   logic [7:0]    buf_data;
   logic          busy;
   logic          done;
   logic          error;
   logic [CW-1:0] blocks_done;

   sd_sector_streamer #(
      .BYTES_PER_BLOCK (512),
      .BUF_ADDR_WIDTH  (AW),
      .CNT_WIDTH       (CW),
      .TIMEOUT_CYCLES  (1000)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .start_block       (start_block),
      .num_blocks        (num_blocks),
      .buf_base          (buf_base),
      .sd_ready          (sd_ready),
      .sd_byte_available (sd_byte_available),
      .sd_dout           (sd_dout),
      .sd_rd             (sd_rd),
      .sd_address        (sd_address),
      .buf_we            (buf_we),
      .buf_addr          (buf_addr),
      .buf_data          (buf_data),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .blocks_done       (blocks_done)
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_checks = 0;

   logic [AW+7:0] exp_wr[$];       // {address, data}
   logic [31:0]   exp_rd_addr[$];
   logic [AW-1:0] exp_ptr = '0;
   int            model_mode  = 0; // 0 normal, 1 never leaves ready, 2 short block
   logic          model_abort = 1'b0;
   int            wr_count   = 0;
   int            done_count = 0;
   int            rd_count   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // SD controller model: reacts to sd_rd while ready, streams a block.
   initial begin : ctrl_model
      logic [31:0] a;
      int nb;
      sd_ready = 1'b1;
      sd_byte_available = 1'b0;
      sd_dout = 8'h00;
      forever begin
         @(negedge clk);
         if (sd_rd === 1'b1 && sd_ready) begin
            a = sd_address;
            rd_count++;
            check("rd_expected", 64'(exp_rd_addr.size() != 0), 64'd1);
            if (exp_rd_addr.size() != 0) check("rd_addr", a, exp_rd_addr.pop_front());
            if (model_mode == 1) begin
               for (int k = 0; k < 5000 && sd_rd === 1'b1; k++) @(negedge clk);
            end else begin
               nb = (model_mode == 2) ? 300 : 512;
               sd_ready = 1'b0;
               repeat (2) @(negedge clk);
               for (int i = 0; i < nb && !model_abort; i++) begin
                  sd_dout = 8'(i) + a[7:0];
                  sd_byte_available = 1'b1;
                  exp_wr.push_back({exp_ptr, sd_dout});
                  exp_ptr = exp_ptr + 1'b1;
                  @(negedge clk);
                  sd_byte_available = 1'b0;
                  @(negedge clk);
               end
               repeat (3) @(negedge clk);
               sd_ready = 1'b1;
            end
         end
      end
   end

   // Write/done monitor sampled mid-cycle.
   always @(negedge clk) begin
      logic [AW+7:0] e;
      if (done === 1'b1) done_count++;
      if (buf_we === 1'b1) begin
         wr_count++;
         check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
         if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", buf_addr, e[AW+7:8]);
            check("wr_data", buf_data, e[7:0]);
         end
      end
   end

   task automatic do_start(input logic [31:0] blk, input logic [CW-1:0] n, input logic [AW-1:0] base);
      exp_ptr = base;
      for (int b = 0; b < n; b++) exp_rd_addr.push_back(blk + 32'(b));
      @(negedge clk);
      start = 1'b1; start_block = blk; num_blocks = n; buf_base = base;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_idle_in_time"}, 64'(busy), 64'd0);
   endtask

   initial begin : stim
      int w0, d0, r0;
      reset = 1'b0; start = 1'b0; start_block = '0; num_blocks = '0; buf_base = '0;
      repeat (3) @(negedge clk);
      check("rst_sd_rd", sd_rd, 0);
      check("rst_sd_address", sd_address, 0);
      check("rst_buf_we", buf_we, 0);
      check("rst_buf_addr", buf_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_blocks_done", blocks_done, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Two blocks from 0x100; a start pulse during busy must be ignored.
      w0 = wr_count; d0 = done_count; r0 = rd_count;
      do_start(32'h100, 16'd2, 17'd0);
      check("t1_busy", busy, 1);
      repeat (50) @(negedge clk);
      start = 1'b1; start_block = 32'h999; num_blocks = 16'd5; buf_base = 17'h500;
      @(negedge clk);
      start = 1'b0;
      wait_idle("t1", 4000);
      @(negedge clk);
      check("t1_writes", wr_count - w0, 1024);
      check("t1_reads", rd_count - r0, 2);
      check("t1_done_pulses", done_count - d0, 1);
      check("t1_blocks_done", blocks_done, 2);
      check("t1_error", error, 0);
      check("t1_sd_address", sd_address, 32'h102);
      check("t1_wr_pending", exp_wr.size(), 0);
      check("t1_rd_pending", exp_rd_addr.size(), 0);

      // Zero blocks: done two cycles after start, no SD traffic.
      d0 = done_count; r0 = rd_count;
      @(negedge clk);
      start = 1'b1; start_block = 32'h77; num_blocks = '0; buf_base = 17'h55;
      @(negedge clk);
      start = 1'b0;
      check("t2_busy_set", busy, 1);
      check("t2_done_early", done, 0);
      @(negedge clk);
      check("t2_done", done, 1);
      check("t2_busy_drop", busy, 0);
      @(negedge clk);
      check("t2_done_single", done, 0);
      check("t2_reads", rd_count - r0, 0);
      check("t2_done_pulses", done_count - d0, 1);
      check("t2_blocks_done", blocks_done, 0);
      check("t2_buf_addr", buf_addr, 17'h55);

      // Buffer address wrap and SD address wrap.
      w0 = wr_count;
      do_start(32'hFFFF_FFFF, 16'd1, 17'h1FFFC);
      wait_idle("t3", 3000);
      @(negedge clk);
      check("t3_writes", wr_count - w0, 512);
      check("t3_last_addr", buf_addr, 17'd507);
      check("t3_sd_address_wrap", sd_address, 0);
      check("t3_error", error, 0);

      // Controller never drops ready: timeout, then a clean run clears error.
      w0 = wr_count; d0 = done_count;
      model_mode = 1;
      do_start(32'h5, 16'd1, 17'd0);
      wait_idle("t4", 3000);
      check("t4_error", error, 1);
      check("t4_sd_rd", sd_rd, 0);
      check("t4_writes", wr_count - w0, 0);
      check("t4_done", done_count - d0, 0);
      model_mode = 0;
      repeat (3) @(negedge clk);
      w0 = wr_count; d0 = done_count;
      do_start(32'h7, 16'd1, 17'h100);
      check("t4b_error_cleared", error, 0);
      wait_idle("t4b", 3000);
      @(negedge clk);
      check("t4b_error", error, 0);
      check("t4b_writes", wr_count - w0, 512);
      check("t4b_done", done_count - d0, 1);

      // Short block: ready returns after 300 bytes.
      w0 = wr_count; d0 = done_count;
      model_mode = 2;
      do_start(32'h9, 16'd1, 17'd0);
      wait_idle("t5", 3000);
      @(negedge clk);
      check("t5_error", error, 1);
      check("t5_writes", wr_count - w0, 300);
      check("t5_done", done_count - d0, 0);
      check("t5_wr_pending", exp_wr.size(), 0);
      model_mode = 0;
      repeat (10) @(negedge clk);

      // Asynchronous reset in the middle of a block.
      w0 = wr_count;
      do_start(32'h20, 16'd2, 17'h40);
      for (int k = 0; k < 3000 && (wr_count - w0) < 200; k++) @(posedge clk);
      check("t6_reached_200", 64'((wr_count - w0) >= 200), 64'd1);
      #3;
      reset = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_buf_we", buf_we, 0);
      check("t6_buf_addr", buf_addr, 0);
      check("t6_buf_data", buf_data, 0);
      check("t6_sd_address", sd_address, 0);
      check("t6_blocks_done", blocks_done, 0);
      check("t6_error", error, 0);
      w0 = wr_count;
      model_abort = 1'b1;
      repeat (10) @(negedge clk);
      exp_wr.delete();
      exp_rd_addr.delete();
      model_abort = 1'b0;
      reset = 1'b1;
      repeat (700) @(negedge clk);
      check("t6_no_writes_after", wr_count - w0, 0);
      check("t6_busy_after", busy, 0);
      check("t6_sd_rd_after", sd_rd, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
